fetch_unit: RTL

Instruction-fetch stage of the pipelined MIPS CPU, directly upstream of the IF/ID pipeline register. Owns the program counter, issues requests to the instruction memory over a variable-latency request/acknowledge handshake, and presents `pc_add_4_o`/`inst_o` for IF/ID to capture on each rising edge. Honours the same `hazard_i` (hold) and branch redirect (IF/ID `flush_i`) that drive IF/ID, and inserts NOP bubbles while memory is slow.

---
 rtl/fetch_unit_if.sv | 15 +
 rtl/fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ack_i;
    logic [XLEN-1:0] imem_data_i;

    modport master (output imem_req_o, output imem_addr_o,
                    input  imem_ack_i, input  imem_data_i);
    modport slave  (input  imem_req_o, input  imem_addr_o,
                    output imem_ack_i, output imem_data_i);
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives the variable-latency imem
// handshake and presents instruction/PC+4 (or a NOP bubble) to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                hazard_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    fetch_unit_if.master        imem,
    output logic [31:0]         pc_add_4_o,
    output logic [31:0]         inst_o,
    output logic                fetch_busy_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic [XLEN-1:0] buf_pc4_q, buf_pc4_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] req_pc4;

    assign target  = {branch_addr_i[XLEN-1:2], 2'b00};
    assign req_pc4 = req_addr_q + XLEN'(4);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
        end
    end

    // Next state and PC/buffer updates; a redirect always wins over a hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        case (state_q)
            IDLE: begin
                if (branch_i) pc_d = target;
                req_addr_d = pc_d;
                state_d    = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack_i) begin
                    if (branch_i) begin
                        pc_d       = target;
                        req_addr_d = target;
                    end else if (hazard_i) begin
                        buf_inst_d = imem.imem_data_i;
                        buf_pc4_d  = req_pc4;
                        state_d    = HOLD;
                    end else begin
                        pc_d       = req_pc4;
                        req_addr_d = req_pc4;
                    end
                end else if (branch_i) begin
                    // The in-flight request must still complete before redirecting.
                    pc_d    = target;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (branch_i) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = FETCH;
                end else if (!hazard_i) begin
                    pc_d       = buf_pc4_q;
                    req_addr_d = buf_pc4_q;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (branch_i) pc_d = target;
                if (imem.imem_ack_i) begin
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus drive and IF/ID presentation; the acked word is forwarded in its ack cycle.
    always_comb begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = req_addr_q;
        inst_o           = '0;
        pc_add_4_o       = '0;
        fetch_busy_o     = 1'b0;
        case (state_q)
            FETCH: begin
                imem.imem_req_o = 1'b1;
                fetch_busy_o    = !imem.imem_ack_i;
                if (imem.imem_ack_i && !branch_i) begin
                    inst_o     = imem.imem_data_i;
                    pc_add_4_o = req_pc4;
                end
            end
            HOLD: begin
                inst_o     = buf_inst_q;
                pc_add_4_o = buf_pc4_q;
            end
            DRAIN: begin
                imem.imem_req_o = 1'b1;
                fetch_busy_o    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
